// File: rtl/core_timer_access.sv
// rtl/core_timer_access.sv - 64-bit mtime/mtimecmp access sequencer over 32-bit timer registers
// Optional three-write mtimecmp update enabled by CORE_TIMER_ACCESS_SAFE_WR_EN.
`ifndef MTIME_ADDR
`define MTIME_ADDR 16'hBFF8
`endif
`ifndef MTIMECMP_ADDR
`define MTIMECMP_ADDR 16'h4000
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

module core_timer_access #(
    parameter logic [15:0] MTIME_BASE    = `MTIME_ADDR,
    parameter logic [15:0] MTIMECMP_BASE = `MTIMECMP_ADDR,
    parameter int          MAX_RETRY     = 3
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [63:0]                cmd_wdata,
    output logic                       rsp_valid,
    output logic [63:0]                rsp_rdata,
    output logic                       rsp_err,
    output logic                       valid_reg_write,
    output logic                       valid_reg_read,
    output logic [15:0]                addr,
    output logic [`AXI_DATA_WIDTH-1:0] write_data,
    input  logic [`AXI_DATA_WIDTH-1:0] read_data,
    input  logic                       read_data_valid
);
    localparam int DW = `AXI_DATA_WIDTH;

    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] RD_H1 = 4'd1;
    localparam logic [3:0] RD_L  = 4'd2;
    localparam logic [3:0] RD_H2 = 4'd3;
    localparam logic [3:0] CMP_L = 4'd4;
    localparam logic [3:0] CMP_H = 4'd5;
    localparam logic [3:0] WR_L0 = 4'd6;
    localparam logic [3:0] WR_H  = 4'd7;
    localparam logic [3:0] WR_L1 = 4'd8;
    localparam logic [3:0] RESP  = 4'd9;

    localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRY);

    logic [3:0]  state;
    logic [31:0] h1;
    logic [31:0] lo;
    logic [7:0]  retry;
    logic [63:0] wdata_q;
    logic [31:0] rd_word;
    logic [31:0] wr_word;

    assign rd_word   = read_data[31:0];
    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state     <= IDLE;
            h1        <= '0;
            lo        <= '0;
            retry     <= '0;
            wdata_q   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        retry     <= '0;
                        wdata_q   <= cmd_wdata;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        case (cmd_op)
                            2'b00: state <= RD_H1;
                            2'b01: state <= CMP_L;
`ifdef CORE_TIMER_ACCESS_SAFE_WR_EN
                            2'b10: state <= WR_L0;
`else
                            2'b10: state <= WR_H;
`endif
                            default: begin
                                rsp_err <= 1'b1;
                                state   <= RESP;
                            end
                        endcase
                    end
                end
                RD_H1: if (read_data_valid) begin
                    h1    <= rd_word;
                    state <= RD_L;
                end
                RD_L: if (read_data_valid) begin
                    lo    <= rd_word;
                    state <= RD_H2;
                end
                RD_H2: if (read_data_valid) begin
                    // A changed high word means lo may belong to either epoch: re-read lo.
                    if (rd_word == h1) begin
                        rsp_rdata <= {rd_word, lo};
                        state     <= RESP;
                    end else if (retry == RETRY_LIMIT) begin
                        rsp_rdata <= {rd_word, lo};
                        rsp_err   <= 1'b1;
                        state     <= RESP;
                    end else begin
                        h1    <= rd_word;
                        retry <= retry + 8'd1;
                        state <= RD_L;
                    end
                end
                CMP_L: if (read_data_valid) begin
                    lo    <= rd_word;
                    state <= CMP_H;
                end
                CMP_H: if (read_data_valid) begin
                    rsp_rdata <= {rd_word, lo};
                    state     <= RESP;
                end
                WR_L0: state <= WR_H;
                WR_H:  state <= WR_L1;
                WR_L1: state <= RESP;
                RESP: begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        valid_reg_read  = 1'b0;
        valid_reg_write = 1'b0;
        addr            = '0;
        wr_word         = '0;
        case (state)
            RD_H1, RD_H2: begin
                valid_reg_read = 1'b1;
                addr           = MTIME_BASE + 16'd4;
            end
            RD_L: begin
                valid_reg_read = 1'b1;
                addr           = MTIME_BASE;
            end
            CMP_L: begin
                valid_reg_read = 1'b1;
                addr           = MTIMECMP_BASE;
            end
            CMP_H: begin
                valid_reg_read = 1'b1;
                addr           = MTIMECMP_BASE + 16'd4;
            end
            // Parking the low word at all-ones keeps mtimecmp above mtime during the update.
            WR_L0: begin
                valid_reg_write = 1'b1;
                addr            = MTIMECMP_BASE;
                wr_word         = 32'hFFFF_FFFF;
            end
            WR_H: begin
                valid_reg_write = 1'b1;
                addr            = MTIMECMP_BASE + 16'd4;
                wr_word         = wdata_q[63:32];
            end
            WR_L1: begin
                valid_reg_write = 1'b1;
                addr            = MTIMECMP_BASE;
                wr_word         = wdata_q[31:0];
            end
            default: ;
        endcase
    end

    assign write_data = DW'(wr_word);

endmodule

// File: tb/tb_core_timer_access.sv
// tb/tb_core_timer_access.sv - randomized self-checking bench for core_timer_access
// Honours CORE_TIMER_ACCESS_SAFE_WR_EN the same way as the design.
`timescale 1ns/1ps
module tb_core_timer_access;
    localparam logic [15:0] MT_B  = 16'hBFF8;
    localparam logic [15:0] CMP_B = 16'h4000;
    localparam int          MAXR  = 3;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [63:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        valid_reg_write;
    logic        valid_reg_read;
    logic [15:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        read_data_valid;

    core_timer_access #(.MTIME_BASE(MT_B), .MTIMECMP_BASE(CMP_B), .MAX_RETRY(MAXR)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .valid_reg_write(valid_reg_write), .valid_reg_read(valid_reg_read),
        .addr(addr), .write_data(write_data),
        .read_data(read_data), .read_data_valid(read_data_valid)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Timer slave: free-running mtime, mtimecmp register pair, programmable read wait states.
    logic [63:0] mtime = '0;
    logic [63:0] mstep = 64'd1;
    logic        mload = 1'b0;
    logic [63:0] mload_val = '0;
    logic [31:0] cmp_lo = '0;
    logic [31:0] cmp_hi = '0;
    int          nwait = 0;
    int          wcnt = 0;
    logic [47:0] wr_log[$];
    int          rsp_cnt = 0;
    int          stab_err = 0;
    int          mutex_err = 0;
    logic        prev_wait = 1'b0;
    logic [15:0] prev_addr = '0;

    always @(posedge ACLK) mtime <= mload ? mload_val : mtime + mstep;

    always_comb begin
        read_data = '0;
        if (addr == MT_B)              read_data = mtime[31:0];
        else if (addr == MT_B + 16'd4) read_data = mtime[63:32];
        else if (addr == CMP_B)        read_data = cmp_lo;
        else if (addr == CMP_B + 16'd4) read_data = cmp_hi;
    end
    assign read_data_valid = valid_reg_read && (wcnt >= nwait);

    always @(posedge ACLK) begin
        wcnt <= (valid_reg_read && !read_data_valid) ? wcnt + 1 : 0;
        if (valid_reg_write) begin
            if (addr == CMP_B) cmp_lo <= write_data;
            if (addr == CMP_B + 16'd4) cmp_hi <= write_data;
            wr_log.push_back({addr, write_data});
        end
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
        if (valid_reg_read && valid_reg_write) mutex_err <= mutex_err + 1;
        if (prev_wait && (!valid_reg_read || addr != prev_addr)) stab_err <= stab_err + 1;
        prev_wait <= valid_reg_read && !read_data_valid;
        prev_addr <= addr;
    end

    // Reference for a tear-free read: mtime(t + k*s) seen at the k-th read cycle.
    task automatic mtime_model(input logic [63:0] t, input logic [63:0] s,
                               output logic [63:0] data, output logic err, output int lat);
        logic [31:0] h1, lo, h2;
        logic [63:0] v;
        int k, r;
        h1 = t[63:32]; k = 1; r = 0; err = 1'b0; lo = '0; h2 = '0;
        do begin
            v  = t + 64'(k) * s;     lo = v[31:0];
            v  = t + 64'(k + 1) * s; h2 = v[63:32];
            if (h2 == h1) break;
            if (r == MAXR) begin err = 1'b1; break; end
            r++; h1 = h2; k += 2;
        end while (1);
        data = {h2, lo};
        lat = 4 + 2 * r;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [63:0] wd, input bit do_load,
                           input logic [63:0] load, output logic [63:0] rdata,
                           output logic err, output int lat);
        @(negedge ACLK);
        cmd_valid = 1'b1; cmd_op = op; cmd_wdata = wd; mload = do_load; mload_val = load;
        @(posedge ACLK);
        #1;
        cmd_valid = 1'b0; mload = 1'b0;
        lat = 0; rdata = '0; err = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge ACLK);
            if (rsp_valid) begin
                lat = k; rdata = rsp_rdata; err = rsp_err;
                break;
            end
        end
    endtask

    logic [63:0] rd, exp_d, t, s, w;
    logic        er, exp_e;
    int          lat, exp_lat, base_cnt, wlat, n;

    initial begin
        #1;
        check("rst_ready", cmd_ready, 1);
        check("rst_strobes", {valid_reg_read, valid_reg_write, rsp_valid, rsp_err}, 0);
        check("rst_bus", {addr, write_data}, 0);
        check("rst_rdata", rsp_rdata, 0);
        @(negedge ACLK); @(negedge ACLK);
        ARESET = 1'b0;

        // Directed mtime read, no rollover.
        mstep = 64'd1;
        run_cmd(2'b00, 0, 1, 64'h0000_0005_0000_0100, rd, er, lat);
        check("mt_dir_data", rd, 64'h0000_0005_0000_0101);
        check("mt_dir_err", er, 0);
        check("mt_dir_lat", lat, 4);

        // Rollover between h1 and h2 forces one retry.
        run_cmd(2'b00, 0, 1, 64'h0000_0000_FFFF_FFFE, rd, er, lat);
        mtime_model(64'h0000_0000_FFFF_FFFE, 64'd1, exp_d, exp_e, exp_lat);
        check("mt_roll_data", rd, exp_d);
        check("mt_roll_err", er, 0);
        check("mt_roll_lat", lat, 6);

        // Randomized mtime reads, including steps that exhaust the retry budget.
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: s = 64'd1;
                1: s = 64'($urandom_range(1, 5));
                2: s = 64'h0000_0000_8000_0000;
                default: s = 64'h0000_0001_0000_0000;
            endcase
            t = {$urandom, $urandom};
            if (i % 3 == 0) t[31:0] = 32'hFFFF_FFFF - 32'($urandom_range(0, 4));
            mstep = s;
            run_cmd(2'b00, 0, 1, t, rd, er, lat);
            mtime_model(t, s, exp_d, exp_e, exp_lat);
            check("mt_rnd_data", rd, exp_d);
            check("mt_rnd_err", er, exp_e);
            check("mt_rnd_lat", lat, exp_lat);
        end
        mstep = 64'd1;

        // Writes followed by read-back with random wait states.
        for (int i = 0; i < 10; i++) begin
            w = (i == 0) ? 64'h0000_0012_3456_789A : {$urandom, $urandom};
            wr_log.delete();
            run_cmd(2'b10, w, 0, 0, rd, er, lat);
`ifdef CORE_TIMER_ACCESS_SAFE_WR_EN
            wlat = 4;
            check("wr_count", wr_log.size(), 3);
            if (wr_log.size() == 3) begin
                check("wr_0", wr_log[0], {CMP_B, 32'hFFFF_FFFF});
                check("wr_1", wr_log[1], {CMP_B + 16'd4, w[63:32]});
                check("wr_2", wr_log[2], {CMP_B, w[31:0]});
            end
`else
            wlat = 3;
            check("wr_count", wr_log.size(), 2);
            if (wr_log.size() == 2) begin
                check("wr_0", wr_log[0], {CMP_B + 16'd4, w[63:32]});
                check("wr_1", wr_log[1], {CMP_B, w[31:0]});
            end
`endif
            check("wr_lat", lat, wlat);
            check("wr_rsp", {er, rd}, 0);
            n = (i == 0) ? 2 : $urandom_range(0, 3);
            nwait = n;
            run_cmd(2'b01, 0, 0, 0, rd, er, lat);
            nwait = 0;
            check("cmp_data", rd, w);
            check("cmp_err", er, 0);
            check("cmp_lat", lat, 3 + 2 * n);
        end

        // Illegal op with overlapping cmd_valid.
        run_cmd(2'b11, 64'hDEAD, 0, 0, rd, er, lat);
        check("ill_lat", lat, 1);
        check("ill_rsp", {er, rd}, {1'b1, 64'h0});

        @(negedge ACLK);
        cmd_valid = 1'b1; cmd_op = 2'b01;
        @(posedge ACLK);
        #1;
        cmd_op = 2'b11;
        n = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge ACLK);
            if (cmd_ready) n++;
        end
        check("ovl_busy_ready", n, 0);
        check("ovl_first_rsp", {rsp_valid, rsp_err}, 2'b10);
        @(negedge ACLK);
        check("ovl_idle_ready", cmd_ready, 1);
        @(posedge ACLK);
        #1;
        cmd_valid = 1'b0;
        @(negedge ACLK);
        check("ovl_second_rsp", {rsp_valid, rsp_err, rsp_rdata}, {2'b11, 64'h0});

        // Reset pulse during RD_L.
        @(negedge ACLK);
        cmd_valid = 1'b1; cmd_op = 2'b00;
        @(posedge ACLK);
        #1;
        cmd_valid = 1'b0;
        @(negedge ACLK);
        @(negedge ACLK);
        check("rr_in_rdl", {valid_reg_read, addr}, {1'b1, MT_B});
        base_cnt = rsp_cnt;
        #1;
        ARESET = 1'b1;
        #1;
        check("rr_strobes", {valid_reg_read, valid_reg_write, addr}, 0);
        @(negedge ACLK);
        ARESET = 1'b0;
        repeat (8) @(negedge ACLK);
        check("rr_no_rsp", rsp_cnt - base_cnt, 0);
        check("rr_ready", cmd_ready, 1);

        check("mutex", mutex_err, 0);
        check("wait_stable", stab_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
